// File: rtl/debounce.sv
// debounce: multi-channel switch/key debouncer.
//   Each channel synchronizes its raw input through a SYNC_STAGES-deep flop chain, then accepts
//   a new level only after it has been sampled unchanged for STABLE_CYCLES consecutive cycles.
//   All state updates happen on the falling edge of i_Clk.
// Ports:
//   i_Clk     - clock (falling-edge active)
//   i_Rst     - asynchronous active-low reset
//   i_Data    - raw asynchronous levels, one bit per channel
//   o_Data    - debounced, registered levels
//   o_Changed - one-cycle strobe per channel when the matching o_Data bit toggles
module debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_Data,
  output logic [WIDTH-1:0] o_Data,
  output logic [WIDTH-1:0] o_Changed
);

  if (WIDTH < 1) begin : g_bad_width
    $error("debounce: WIDTH must be >= 1");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("debounce: STABLE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce: SYNC_STAGES must be >= 2");
  end

  // Guarded so an illegal STABLE_CYCLES still elaborates far enough to report the error above.
  localparam int CntW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StPending = 1'b1;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sample;

  logic [WIDTH-1:0] r_state, w_state_d;
  logic [WIDTH-1:0] r_data, w_data_d;
  logic [WIDTH-1:0] r_changed, w_changed_d;
  logic [CntW-1:0]  r_cnt [WIDTH];
  logic [CntW-1:0]  w_cnt_d [WIDTH];

  always_ff @(negedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= i_Data;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_sample = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_d   = r_state;
    w_data_d    = r_data;
    w_changed_d = '0;
    for (int c = 0; c < WIDTH; c++) begin
      w_cnt_d[c] = r_cnt[c];
      unique case (r_state[c])
        StIdle: begin
          if (w_sample[c] != r_data[c]) begin
            // A one-cycle stability window accepts on the very first differing sample.
            if (CntMax == '0) begin
              w_data_d[c]    = w_sample[c];
              w_changed_d[c] = 1'b1;
              w_cnt_d[c]     = '0;
            end else begin
              w_state_d[c] = StPending;
              w_cnt_d[c]   = CntW'(1);
            end
          end else begin
            w_cnt_d[c] = '0;
          end
        end
        StPending: begin
          if (w_sample[c] == r_data[c]) begin
            // Bounce back to the accepted level: drop the partial count.
            w_state_d[c] = StIdle;
            w_cnt_d[c]   = '0;
          end else if (r_cnt[c] == CntMax) begin
            w_data_d[c]    = w_sample[c];
            w_changed_d[c] = 1'b1;
            w_cnt_d[c]     = '0;
            w_state_d[c]   = StIdle;
          end else begin
            w_cnt_d[c] = r_cnt[c] + CntW'(1);
          end
        end
        default: begin
          w_state_d[c] = StIdle;
          w_cnt_d[c]   = '0;
        end
      endcase
    end
  end

  always_ff @(negedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state   <= {WIDTH{StIdle}};
      r_data    <= '0;
      r_changed <= '0;
      for (int c = 0; c < WIDTH; c++) begin
        r_cnt[c] <= '0;
      end
    end else begin
      r_state   <= w_state_d;
      r_data    <= w_data_d;
      r_changed <= w_changed_d;
      for (int c = 0; c < WIDTH; c++) begin
        r_cnt[c] <= w_cnt_d[c];
      end
    end
  end

  assign o_Data    = r_data;
  assign o_Changed = r_changed;

endmodule

// File: tb/tb_debounce.sv
// tb_debounce: scoreboard bench for debounce (WIDTH=4, STABLE_CYCLES=4, SYNC_STAGES=2).
//   Stimulus pushes expected o_Changed events {edge, o_Data, o_Changed} into a queue; a monitor
//   on the rising edge pops and compares whenever the DUT strobes o_Changed.
module tb_debounce;

  localparam int W   = 4;
  localparam int SC  = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + SC;

  logic         i_Clk  = 1'b0;
  logic         i_Rst  = 1'b0;
  logic [W-1:0] i_Data = '0;
  logic [W-1:0] o_Data;
  logic [W-1:0] o_Changed;

  debounce #(
    .WIDTH        (W),
    .STABLE_CYCLES(SC),
    .SYNC_STAGES  (SS)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Data   (i_Data),
    .o_Data   (o_Data),
    .o_Changed(o_Changed)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int           edge_n;
    logic [W-1:0] data;
    logic [W-1:0] chg;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;
  int n_edge  = 0;
  bit use_model = 1'b0;

  // Reference model for the random phase: two-stage sampler plus a run-length of differing samples.
  logic [W-1:0] m_sync0 = '0;
  logic [W-1:0] m_sync1 = '0;
  logic [W-1:0] m_out   = '0;
  logic [W-1:0] m_chg;
  logic [W-1:0] prev_data = '0;
  int           m_run [W];
  bit           cnt_ok;

  always @(negedge i_Clk) begin
    n_edge++;
    m_chg = '0;
    if (!i_Rst) begin
      m_sync0 = '0;
      m_sync1 = '0;
      m_out   = '0;
      for (int c = 0; c < W; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < W; c++) begin
        if (m_sync1[c] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == SC) begin
            m_out[c] = m_sync1[c];
            m_run[c] = 0;
            m_chg[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_sync1 = m_sync0;
      m_sync0 = i_Data;
      if (use_model && m_chg != '0) q.push_back('{n_edge, m_out, m_chg});
    end
  end

  // Monitor: every strobe must match the head of the queue; overdue entries are missed pulses.
  always @(posedge i_Clk) begin
    if (q.size() != 0 && q[0].edge_n < n_edge) begin
      mon_e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_pulse: no strobe observed by edge %0d, required edge %0d data=%h chg=%h",
               n_edge, mon_e.edge_n, mon_e.data, mon_e.chg);
    end
    if (i_Rst && o_Changed != '0) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: edge %0d data=%h chg=%h, required no pulse",
                 n_edge, o_Data, o_Changed);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.edge_n != n_edge || o_Data !== mon_e.data || o_Changed !== mon_e.chg) begin
          n_fail++;
          $display("FAIL pulse: got edge %0d data=%h chg=%h, required edge %0d data=%h chg=%h",
                   n_edge, o_Data, o_Changed, mon_e.edge_n, mon_e.data, mon_e.chg);
        end
      end
    end
  end

  // Random-phase properties: strobe == toggle, output follows model latency, counter bounded.
  always @(posedge i_Clk) begin
    if (use_model) begin
      n_tests++;
      assert (o_Changed === (o_Data ^ prev_data)) else begin
        n_fail++;
        $display("FAIL strobe_vs_toggle: chg=%h, required %h", o_Changed, o_Data ^ prev_data);
      end
      prev_data = o_Data;
      n_tests++;
      assert (o_Data === m_out) else begin
        n_fail++;
        $display("FAIL latency_model: data=%h, required %h at edge %0d", o_Data, m_out, n_edge);
      end
      cnt_ok = 1'b1;
      for (int c = 0; c < W; c++) begin
        if (dut.r_cnt[c] > SC - 1) cnt_ok = 1'b0;
      end
      n_tests++;
      assert (cnt_ok) else begin
        n_fail++;
        $display("FAIL counter_bound: a channel counter exceeds %0d at edge %0d", SC - 1, n_edge);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_Clk);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called right after driving a step at a rising edge: acceptance lands LAT falling edges later.
  task automatic expect_pulse(input logic [W-1:0] data, input logic [W-1:0] chg);
    q.push_back('{n_edge + LAT, data, chg});
  endtask

  initial begin
    // Reset held with all inputs high, then release: all channels accept together.
    i_Rst  = 1'b0;
    i_Data = 4'hF;
    tick(3);
    check("rst_data", o_Data, 4'h0);
    check("rst_chg", o_Changed, 4'h0);
    i_Rst = 1'b1;
    expect_pulse(4'hF, 4'hF);
    tick(LAT + 2);
    check("post_rst_data", o_Data, 4'hF);

    i_Data = 4'h0;
    expect_pulse(4'h0, 4'hF);
    tick(LAT + 2);
    check("fall_all", o_Data, 4'h0);

    // Three-cycle glitch on channel 0 is rejected.
    i_Data = 4'h1;
    tick(3);
    i_Data = 4'h0;
    tick(10);
    check("short_glitch", o_Data, 4'h0);

    // Bouncing channel 1, then held high.
    i_Data = 4'h2; tick(1);
    i_Data = 4'h0; tick(1);
    i_Data = 4'h2; tick(1);
    i_Data = 4'h0; tick(1);
    i_Data = 4'h2;
    expect_pulse(4'h2, 4'h2);
    tick(LAT + 2);
    check("bounce", o_Data, 4'h2);

    i_Data = 4'h0;
    expect_pulse(4'h0, 4'h2);
    tick(LAT + 2);
    check("bounce_release", o_Data, 4'h0);

    // Channels 2 and 3 rise together; channel 3 drops early.
    i_Data = 4'hC;
    expect_pulse(4'h4, 4'h4);
    tick(2);
    i_Data = 4'h4;
    tick(LAT + 2);
    check("pair", o_Data, 4'h4);

    // Simultaneous fall on channel 2 and rise on channel 0.
    i_Data = 4'h1;
    expect_pulse(4'h1, 4'h5);
    tick(LAT + 2);
    check("swap", o_Data, 4'h1);

    // Reset mid-count discards the pending fall on channel 0.
    i_Data = 4'h0;
    tick(3);
    check("pre_rst_data", o_Data, 4'h1);
    #1 i_Rst = 1'b0;
    #1;
    check("rst_async_data", o_Data, 4'h0);
    check("rst_async_chg", o_Changed, 4'h0);
    tick(2);
    i_Rst = 1'b1;
    tick(12);
    check("quiet_after_rst", o_Data, 4'h0);

    // Random toggling on all channels, checked against the model.
    prev_data = o_Data;
    use_model = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      tick(1);
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(0, 5) == 0) i_Data[c] = ~i_Data[c];
      end
    end
    tick(LAT + 4);
    for (int t = 0; t < 20 && q.size() != 0; t++) tick(1);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected pulses outstanding, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of independent input channels (>= 1).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 1000: consecutive sampled cycles a new level must hold before acceptance (>= 1).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per channel (>= 2).
REQ-004 The block SHALL have port i_Clk  input  1  the single clock; all state updates on its falling edge.
REQ-005 The block SHALL have port i_Rst  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_Data  input  WIDTH  raw asynchronous levels (buttons/keys).
REQ-007 The block SHALL have port o_Data  output  WIDTH  debounced, registered levels; feeds the pulse stage downstream.
REQ-008 The block SHALL have port o_Changed  output  WIDTH  registered one-cycle strobe per channel when the matching o_Data bit toggles.

Function
REQ-009 Each channel SHALL pass i_Data through a SYNC_STAGES-deep falling-edge flop chain; the last stage is the sampled value S.
REQ-010 Each channel SHALL hold an independent counter of width clog2(STABLE_CYCLES+1) and a 2-state FSM: IDLE (S == o_Data bit) and PENDING (S != o_Data bit, counting).
REQ-011 In IDLE, if S equals o_Data the counter SHALL stay 0; if S differs the FSM SHALL enter PENDING with counter <= 1, unless STABLE_CYCLES == 1, in which case the accept action of REQ-013 SHALL occur on that edge.
REQ-012 In PENDING, if S returns to o_Data (glitch/bounce) the FSM SHALL return to IDLE with counter <= 0 and o_Data unchanged.
REQ-013 In PENDING, if S still differs and counter == STABLE_CYCLES-1, the block SHALL set o_Data bit <= S, counter <= 0, o_Changed bit <= 1 and return to IDLE; otherwise counter SHALL increment by 1.
REQ-014 o_Changed bits SHALL be 1 for exactly one cycle per accepted change and 0 at all other times.
REQ-015 Latency from an i_Data step, stable and set up before falling edge 1, to the o_Data update SHALL be exactly SYNC_STAGES + STABLE_CYCLES falling edges.
REQ-016 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be accepted on their own schedule, and the corresponding o_Changed bits may assert together.
REQ-017 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-018 Rising and falling transitions SHALL be treated symmetrically; no edge preference.
REQ-019 Illegal parameters (STABLE_CYCLES < 1, SYNC_STAGES < 2, WIDTH < 1) SHALL be flagged by an elaboration-time error.

Reset
REQ-020 When i_Rst is 0, immediately and independently of i_Clk: all synchronizer flops, counters and o_Data SHALL be 0, o_Changed SHALL be 0, and every FSM SHALL be in IDLE.
REQ-021 Assertion of i_Rst mid-count SHALL discard the pending count, and no o_Changed pulse SHALL be emitted for it.
REQ-022 After i_Rst deasserts, an input held at 1 SHALL be accepted as a normal 0->1 change per REQ-015, producing one o_Changed pulse.

Verification (WIDTH=4, STABLE_CYCLES=4, SYNC_STAGES=2)
REQ-023 Hold i_Rst=0 with i_Data=4'hF, then release -> o_Data=4'h0 during reset; at falling edge 6 after release o_Data=4'hF and o_Changed=4'hF for one cycle, then 4'h0.
REQ-024 Drive i_Data[0]=1 for 3 cycles, then 0 -> o_Data[0] stays 0 and o_Changed stays 4'h0 throughout.
REQ-025 Drive i_Data[1] bouncing 1,0,1,0,1 (1 cycle each), then held at 1 -> exactly one o_Changed[1] pulse, 6 edges after the final 0->1, and o_Data[1]=1.
REQ-026 Raise i_Data[2] and i_Data[3] together, then drop i_Data[3] after 2 cycles -> o_Data=4'h4 after 6 edges with o_Changed=4'h4 only, and o_Data[3] never set.
REQ-027 With o_Data[0]=1 stable, drive i_Data[0]=0 and assert i_Rst after 3 edges -> o_Data=0 asynchronously and no o_Changed pulse; after release with i_Data[0]=0 there is no activity.
REQ-028 Bench SHALL check REQ-014, REQ-015 and REQ-017 with assertions over a 10k-cycle random-input run on all channels.
